dmem_arbiter: RTL and testbench

Two-port arbiter and access sequencer for the byte-enabled data memory (`DATA_MEMORY_V2`). It shares the single memory port between requester A (core load/store unit) and requester B (debug/loader port) with round-robin fairness. It converts byte/half/word requests into aligned word addresses, byte-write masks and replicated write data, and returns sign- or zero-extended load data. The block sits between the requesters and the memory.

---
 rtl/dmem_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and access sequencer that shares one byte-enabled data memory port
// between two requesters, handling byte/half/word alignment, write masks and load extension.
module dmem_arbiter #(
  parameter int HEIGHT = 256
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_a_req,
  input  logic        i_a_we,
  input  logic [1:0]  i_a_size,
  input  logic        i_a_unsigned,
  input  logic [31:0] i_a_addr,
  input  logic [31:0] i_a_wd,
  output logic        o_a_gnt,
  output logic        o_a_err,
  output logic        o_a_rvalid,
  output logic [31:0] o_a_rd,
  input  logic        i_b_req,
  input  logic        i_b_we,
  input  logic [1:0]  i_b_size,
  input  logic        i_b_unsigned,
  input  logic [31:0] i_b_addr,
  input  logic [31:0] i_b_wd,
  output logic        o_b_gnt,
  output logic        o_b_err,
  output logic        o_b_rvalid,
  output logic [31:0] o_b_rd,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wd,
  output logic [3:0]  o_mem_wen,
  output logic        o_mem_ren,
  input  logic [31:0] i_mem_rd
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e      state_q;
  logic        lastB_q, selB_q, isLoad_q, uns_q;
  logic [1:0]  size_q, lane_q;
  logic        gntA_q, errA_q, rvalidA_q, gntB_q, errB_q, rvalidB_q;
  logic [31:0] rdA_q, rdB_q, memAddr_q, memWd_q;
  logic [3:0]  memWen_q;
  logic        memRen_q;

  logic        pickB_d, anyReq_d, selWe_d, selUns_d, err_d;
  logic [1:0]  selSize_d;
  logic [31:0] selAddr_d, selWd_d, wd_d, loadData_d;
  logic [3:0]  wen_d;
  logic [7:0]  byteField;
  logic [15:0] halfField;

  // Tie-break goes to whichever requester was not granted last
  always_comb begin
    anyReq_d  = i_a_req | i_b_req;
    pickB_d   = i_b_req && (!i_a_req || !lastB_q);
    selWe_d   = pickB_d ? i_b_we       : i_a_we;
    selSize_d = pickB_d ? i_b_size     : i_a_size;
    selUns_d  = pickB_d ? i_b_unsigned : i_a_unsigned;
    selAddr_d = pickB_d ? i_b_addr     : i_a_addr;
    selWd_d   = pickB_d ? i_b_wd       : i_a_wd;

    err_d = (selSize_d == 2'b11)
         || (selSize_d == 2'b01 && selAddr_d[0])
         || (selSize_d == 2'b10 && selAddr_d[1:0] != 2'b00)
         || ((selAddr_d >> 2) >= 32'(HEIGHT));

    wen_d = 4'b0000;
    wd_d  = 32'h0;
    case (selSize_d)
      2'b00: begin
        wen_d = 4'b0001 << selAddr_d[1:0];
        wd_d  = {4{selWd_d[7:0]}};
      end
      2'b01: begin
        wen_d = 4'b0011 << selAddr_d[1:0];
        wd_d  = {2{selWd_d[15:0]}};
      end
      2'b10: begin
        wen_d = 4'b1111;
        wd_d  = selWd_d;
      end
      default: begin
        wen_d = 4'b0000;
        wd_d  = 32'h0;
      end
    endcase

    case (lane_q)
      2'd0:    byteField = i_mem_rd[7:0];
      2'd1:    byteField = i_mem_rd[15:8];
      2'd2:    byteField = i_mem_rd[23:16];
      default: byteField = i_mem_rd[31:24];
    endcase
    halfField = lane_q[1] ? i_mem_rd[31:16] : i_mem_rd[15:0];

    case (size_q)
      2'b00:   loadData_d = uns_q ? {24'h0, byteField} : {{24{byteField[7]}}, byteField};
      2'b01:   loadData_d = uns_q ? {16'h0, halfField} : {{16{halfField[15]}}, halfField};
      default: loadData_d = i_mem_rd;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      lastB_q   <= 1'b1;
      selB_q    <= 1'b0;
      isLoad_q  <= 1'b0;
      uns_q     <= 1'b0;
      size_q    <= 2'b00;
      lane_q    <= 2'b00;
      gntA_q    <= 1'b0;
      errA_q    <= 1'b0;
      rvalidA_q <= 1'b0;
      rdA_q     <= 32'h0;
      gntB_q    <= 1'b0;
      errB_q    <= 1'b0;
      rvalidB_q <= 1'b0;
      rdB_q     <= 32'h0;
      memAddr_q <= 32'h0;
      memWd_q   <= 32'h0;
      memWen_q  <= 4'b0000;
      memRen_q  <= 1'b0;
    end else begin
      gntA_q    <= 1'b0;
      errA_q    <= 1'b0;
      rvalidA_q <= 1'b0;
      rdA_q     <= 32'h0;
      gntB_q    <= 1'b0;
      errB_q    <= 1'b0;
      rvalidB_q <= 1'b0;
      rdB_q     <= 32'h0;
      memWd_q   <= 32'h0;
      memWen_q  <= 4'b0000;
      memRen_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (anyReq_d) begin
            state_q  <= ISSUE;
            lastB_q  <= pickB_d;
            selB_q   <= pickB_d;
            isLoad_q <= !err_d && !selWe_d;
            uns_q    <= selUns_d;
            size_q   <= selSize_d;
            lane_q   <= selAddr_d[1:0];
            gntA_q   <= !pickB_d;
            gntB_q   <= pickB_d;
            errA_q   <= !pickB_d && err_d;
            errB_q   <= pickB_d && err_d;
            // Rejected accesses leave the memory address and strobes untouched
            if (!err_d) begin
              memAddr_q <= selAddr_d & ~32'd3;
              if (selWe_d) begin
                memWen_q <= wen_d;
                memWd_q  <= wd_d;
              end else begin
                memRen_q <= 1'b1;
              end
            end
          end
        end
        ISSUE: state_q <= isLoad_q ? WAIT : IDLE;
        WAIT: begin
          state_q <= RESP;
          if (selB_q) begin
            rvalidB_q <= 1'b1;
            rdB_q     <= loadData_d;
          end else begin
            rvalidA_q <= 1'b1;
            rdA_q     <= loadData_d;
          end
        end
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_a_gnt    = gntA_q;
  assign o_a_err    = errA_q;
  assign o_a_rvalid = rvalidA_q;
  assign o_a_rd     = rdA_q;
  assign o_b_gnt    = gntB_q;
  assign o_b_err    = errB_q;
  assign o_b_rvalid = rvalidB_q;
  assign o_b_rd     = rdB_q;
  assign o_mem_addr = memAddr_q;
  assign o_mem_wd   = memWd_q;
  assign o_mem_wen  = memWen_q;
  assign o_mem_ren  = memRen_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-enabled synchronous-read memory model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        aReq = 0, aWe = 0, aUns = 0, bReq = 0, bWe = 0, bUns = 0;
  logic [1:0]  aSize = 0, bSize = 0;
  logic [31:0] aAddr = 0, aWd = 0, bAddr = 0, bWd = 0;
  logic        aGnt, aErr, aRvalid, bGnt, bErr, bRvalid;
  logic [31:0] aRd, bRd, memAddr, memWd, memRd;
  logic [3:0]  memWen;
  logic        memRen;

  logic [31:0] mem [256];
  logic [31:0] refWords [256];
  int          testsRun = 0;
  int          testsFailed = 0;
  int          bothStrobes = 0;

  dmem_arbiter #(.HEIGHT(256)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_a_req(aReq), .i_a_we(aWe), .i_a_size(aSize), .i_a_unsigned(aUns),
    .i_a_addr(aAddr), .i_a_wd(aWd),
    .o_a_gnt(aGnt), .o_a_err(aErr), .o_a_rvalid(aRvalid), .o_a_rd(aRd),
    .i_b_req(bReq), .i_b_we(bWe), .i_b_size(bSize), .i_b_unsigned(bUns),
    .i_b_addr(bAddr), .i_b_wd(bWd),
    .o_b_gnt(bGnt), .o_b_err(bErr), .o_b_rvalid(bRvalid), .o_b_rd(bRd),
    .o_mem_addr(memAddr), .o_mem_wd(memWd), .o_mem_wen(memWen), .o_mem_ren(memRen),
    .i_mem_rd(memRd)
  );

  always #5 clk = ~clk;

  // Memory model: cleared on reset so every run starts from a known image
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      memRd <= 32'h0;
    end else begin
      for (int l = 0; l < 4; l++)
        if (memWen[l]) mem[memAddr[9:2]][8*l +: 8] <= memWd[8*l +: 8];
      if (memRen) memRd <= mem[memAddr[9:2]];
    end
  end

  always @(negedge clk)
    if (memRen && |memWen) bothStrobes++;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit side, input bit we, input logic [1:0] size,
                               input bit uns, input logic [31:0] addr, input logic [31:0] wd);
    if (side) begin
      bReq = 1; bWe = we; bSize = size; bUns = uns; bAddr = addr; bWd = wd;
    end else begin
      aReq = 1; aWe = we; aSize = size; aUns = uns; aAddr = addr; aWd = wd;
    end
  endtask

  task automatic dropReqs();
    aReq = 0;
    bReq = 0;
  endtask

  task automatic storeOp(input bit side, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] expWen, input logic [31:0] expWd);
    applyStimulus(side, 1'b1, size, 1'b0, addr, wd);
    @(posedge clk); #1;
    checkOutput("store gnt", {31'h0, side ? bGnt : aGnt}, 32'h1);
    checkOutput("store other gnt", {31'h0, side ? aGnt : bGnt}, 32'h0);
    checkOutput("store addr", memAddr, addr & ~32'd3);
    checkOutput("store wen", {28'h0, memWen}, {28'h0, expWen});
    checkOutput("store wd", memWd, expWd);
    checkOutput("store ren", {31'h0, memRen}, 32'h0);
    dropReqs();
    @(posedge clk); #1;
    checkOutput("store strobes off", {27'h0, memWen, memRen}, 32'h0);
  endtask

  task automatic loadOp(input bit side, input logic [1:0] size, input bit uns,
                        input logic [31:0] addr, input logic [31:0] expRd);
    applyStimulus(side, 1'b0, size, uns, addr, 32'h0);
    @(posedge clk); #1;
    checkOutput("load gnt", {31'h0, side ? bGnt : aGnt}, 32'h1);
    checkOutput("load ren", {27'h0, memWen, memRen}, 32'h1);
    checkOutput("load addr", memAddr, addr & ~32'd3);
    dropReqs();
    @(posedge clk); #1;
    checkOutput("load early rvalid", {30'h0, aRvalid, bRvalid}, 32'h0);
    @(posedge clk); #1;
    checkOutput("load rvalid", {30'h0, aRvalid, bRvalid}, side ? 32'h1 : 32'h2);
    checkOutput("load rd", side ? bRd : aRd, expRd);
    checkOutput("load other rd", side ? aRd : bRd, 32'h0);
    @(posedge clk); #1;
    checkOutput("load rvalid off", {30'h0, aRvalid, bRvalid}, 32'h0);
  endtask

  task automatic errOp(input string tag, input logic [1:0] size, input logic [31:0] addr);
    applyStimulus(1'b0, 1'b1, size, 1'b0, addr, 32'hDEADBEEF);
    @(posedge clk); #1;
    checkOutput(tag, {26'h0, aGnt, aErr, memWen}, {26'h0, 1'b1, 1'b1, 4'b0000});
    checkOutput({tag, " ren"}, {31'h0, memRen}, 32'h0);
    dropReqs();
    @(posedge clk); #1;
  endtask

  int gntSide[$];
  int gntCycle[$];
  int rvSeen;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset flags", {22'h0, aGnt, aErr, aRvalid, bGnt, bErr, bRvalid, memWen}, 32'h0);
    checkOutput("reset addr", memAddr, 32'h0);
    checkOutput("reset rd", aRd | bRd | memWd, 32'h0);
    rst = 0;

    storeOp(1'b0, 2'b10, 32'h4, 32'h11223344, 4'b1111, 32'h11223344);
    storeOp(1'b0, 2'b00, 32'h5, 32'h000000A5, 4'b0010, 32'hA5A5A5A5);
    checkOutput("byte merge", mem[1], 32'h1122A544);
    storeOp(1'b1, 2'b01, 32'hE, 32'h0000BEEF, 4'b1100, 32'hBEEFBEEF);
    checkOutput("half merge", mem[3], 32'hBEEF0000);
    storeOp(1'b0, 2'b10, 32'h8, 32'h80FF1234, 4'b1111, 32'h80FF1234);

    loadOp(1'b0, 2'b00, 1'b0, 32'hB, 32'hFFFFFF80);
    loadOp(1'b0, 2'b00, 1'b1, 32'hB, 32'h00000080);
    loadOp(1'b0, 2'b01, 1'b0, 32'hA, 32'hFFFF80FF);
    loadOp(1'b1, 2'b10, 1'b0, 32'h8, 32'h80FF1234);
    loadOp(1'b1, 2'b00, 1'b0, 32'h8, 32'h00000034);
    loadOp(1'b1, 2'b01, 1'b1, 32'hA, 32'h000080FF);

    errOp("err word 0x6", 2'b10, 32'h6);
    errOp("err half 0x3", 2'b01, 32'h3);
    errOp("err size 11", 2'b11, 32'h0);
    errOp("err word 0x400", 2'b10, 32'h400);
    checkOutput("err mem0", mem[0], 32'h0);
    checkOutput("err mem1", mem[1], 32'h1122A544);

    // Both requesters hold stores straight out of reset
    rst = 1;
    applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hAAAA0000);
    applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 32'h14, 32'hBBBB0000);
    @(posedge clk); #1;
    rst = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (aGnt) begin gntSide.push_back(0); gntCycle.push_back(k); end
      if (bGnt) begin gntSide.push_back(1); gntCycle.push_back(k); end
    end
    dropReqs();
    checkOutput("contention count", gntSide.size(), 32'd4);
    for (int i = 0; i < gntSide.size() && i < 4; i++) begin
      checkOutput("contention side", gntSide[i], i % 2);
      checkOutput("contention cycle", gntCycle[i], 2 * i + 1);
    end
    @(posedge clk); #1;

    // Reset in the WAIT cycle of a load granted to A
    applyStimulus(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    @(posedge clk); #1;
    checkOutput("rstwait gnt", {31'h0, aGnt}, 32'h1);
    dropReqs();
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    rvSeen = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (aRvalid || bRvalid) rvSeen++;
    end
    checkOutput("rstwait no rvalid", rvSeen, 32'd0);
    applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h1);
    applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 32'h24, 32'h2);
    @(posedge clk); #1;
    checkOutput("rst tie to A", {30'h0, aGnt, bGnt}, 32'h2);
    dropReqs();
    @(posedge clk); #1;

    for (int i = 0; i < 256; i++) refWords[i] = $urandom;
    for (int i = 0; i < 256; i++)
      storeOp(1'b1, 2'b10, 32'(i * 4), refWords[i], 4'b1111, refWords[i]);
    for (int i = 0; i < 256; i++)
      loadOp(1'b0, 2'b10, 1'b0, 32'(i * 4), refWords[i]);
    checkOutput("ren and wen together", bothStrobes, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
